// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data cache data bank.
package dcache_pkg;

  localparam int unsigned LINE_BYTES_DEF = 32;
  localparam int unsigned LINE_W_DEF     = 8 * LINE_BYTES_DEF;

  // Bank sequencing: zero-fill sweep, then normal operation.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ceiling log2 with a floor of 1 so a single-set array still has an index bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/dcache_way_ram.sv
// One cache way: simple dual-port byte-write RAM, read-first, one-cycle read.
module dcache_way_ram
  import dcache_pkg::*;
#(
  parameter int unsigned SETS       = 128,
  parameter int unsigned LINE_BYTES = LINE_BYTES_DEF,
  localparam int unsigned IDX_W     = clog2(SETS),
  localparam int unsigned LINE_W    = 8 * LINE_BYTES
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LINE_BYTES-1:0] wstrb,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [LINE_W-1:0]     wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [LINE_W-1:0]     rdata
);

  logic [LINE_W-1:0] mem [SETS];

  // Byte-strobed write and read-first registered read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < LINE_BYTES; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dcache_data_bank.sv
// L1 dcache data array: WAYS parallel ways, byte-strobed writes, same-cycle
// write-to-read forwarding, 1 or 2 cycle read latency, optional zero-fill.
module dcache_data_bank
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS          = 2,
  parameter int unsigned SETS          = 128,
  parameter int unsigned LINE_BYTES    = LINE_BYTES_DEF,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned INIT_ON_RESET = 1,
  localparam int unsigned IDX_W        = clog2(SETS),
  localparam int unsigned LINE_W       = 8 * LINE_BYTES
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_busy,
  input  logic                     ren,
  input  logic [IDX_W-1:0]         rindex,
  input  logic [WAYS-1:0]          wen,
  input  logic [LINE_BYTES-1:0]    wstrb,
  input  logic [IDX_W-1:0]         windex,
  input  logic [LINE_W-1:0]        wdata,
  output logic                     rvalid,
  output logic [WAYS*LINE_W-1:0]   rdata
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              sweeping;
  logic              run;
  logic              rd_en;

  logic [WAYS-1:0]       ram_we;
  logic [LINE_BYTES-1:0] ram_wstrb;
  logic [IDX_W-1:0]      ram_waddr;
  logic [LINE_W-1:0]     ram_wdata;
  logic [LINE_W-1:0]     ram_rdata [WAYS];

  logic                  v1_q;
  logic [WAYS-1:0]       coll_q;
  logic [LINE_BYTES-1:0] wstrb_q;
  logic [LINE_W-1:0]     wdata_q;
  logic [WAYS*LINE_W-1:0] merged;

  assign init_busy = (state_q == ST_INIT);
  assign sweeping  = (state_q == ST_INIT) & ~rst;
  assign run       = (state_q == ST_RUN) & ~rst;
  assign rd_en     = run & ren;

  // State register and sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep every set once, then hand over to normal operation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(SETS - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Write port mux: sweep zero-fill owns the port during INIT.
  always_comb begin
    ram_we    = run ? wen : '0;
    ram_wstrb = wstrb;
    ram_waddr = windex;
    ram_wdata = wdata;
    if (sweeping) begin
      ram_we    = '1;
      ram_wstrb = '1;
      ram_waddr = cnt_q;
      ram_wdata = '0;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way_ram #(
      .SETS       (SETS),
      .LINE_BYTES (LINE_BYTES)
    ) u_ram (
      .clk   (clk),
      .we    (ram_we[w]),
      .wstrb (ram_wstrb),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (rd_en),
      .raddr (rindex),
      .rdata (ram_rdata[w])
    );
  end

  // Capture same-cycle write collisions alongside the read request.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      coll_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      v1_q <= rd_en;
      if (rd_en) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          coll_q[w] <= wen[w] & (windex == rindex);
        end
        wstrb_q <= wstrb;
        wdata_q <= wdata;
      end
    end
  end

  // Byte-wise merge of forwarded write data over the read-first RAM output.
  always_comb begin
    merged = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      for (int unsigned b = 0; b < LINE_BYTES; b++) begin
        merged[w*LINE_W + b*8 +: 8] = (coll_q[w] & wstrb_q[b]) ? wdata_q[b*8 +: 8]
                                                                : ram_rdata[w][b*8 +: 8];
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    logic [WAYS*LINE_W-1:0] last_q;

    // Hold the last completed read so rdata is stable between reads.
    always_ff @(posedge clk) begin
      if (rst)       last_q <= '0;
      else if (v1_q) last_q <= merged;
    end

    assign rvalid = v1_q;
    assign rdata  = v1_q ? merged : last_q;
  end else if (READ_LATENCY == 2) begin : g_lat2
    logic                   rvalid_q;
    logic [WAYS*LINE_W-1:0] rdata_q;

    // Extra output stage; rdata only updates when a read completes.
    always_ff @(posedge clk) begin
      if (rst) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= v1_q;
        if (v1_q) rdata_q <= merged;
      end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
  end else begin : g_bad_latency
    $error("dcache_data_bank: READ_LATENCY must be 1 or 2");
    assign rvalid = 1'b0;
    assign rdata  = '0;
  end

endmodule

// File: tb/tb_dcache_data_bank.sv
// Self-checking bench: two banks (read latency 1 and 2) driven in parallel and
// compared against a line-level reference model plus directed vectors.
module tb_dcache_data_bank;

  localparam int unsigned WAYS = 2;
  localparam int unsigned SETS = 8;
  localparam int unsigned LB   = 32;
  localparam int unsigned LW   = 8 * LB;
  localparam int unsigned IW   = 3;

  logic              clk;
  logic              rst;
  logic              ren;
  logic [IW-1:0]     rindex;
  logic [WAYS-1:0]   wen;
  logic [LB-1:0]     wstrb;
  logic [IW-1:0]     windex;
  logic [LW-1:0]     wdata;
  logic              busy1, busy2, rv1, rv2;
  logic [WAYS*LW-1:0] rd1, rd2;

  dcache_data_bank #(
    .WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LB), .READ_LATENCY(1), .INIT_ON_RESET(1)
  ) u_l1 (
    .clk(clk), .rst(rst), .init_busy(busy1), .ren(ren), .rindex(rindex),
    .wen(wen), .wstrb(wstrb), .windex(windex), .wdata(wdata),
    .rvalid(rv1), .rdata(rd1)
  );

  dcache_data_bank #(
    .WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LB), .READ_LATENCY(2), .INIT_ON_RESET(1)
  ) u_l2 (
    .clk(clk), .rst(rst), .init_busy(busy2), .ren(ren), .rindex(rindex),
    .wen(wen), .wstrb(wstrb), .windex(windex), .wdata(wdata),
    .rvalid(rv2), .rdata(rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: line contents and read results in flight.
  logic [LW-1:0]      mem_m [WAYS][SETS];
  int                 busy_left;
  logic               mv1, mv2;
  logic [WAYS*LW-1:0] md1, md2, last1, last2;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    logic               acc;
    logic [WAYS*LW-1:0] rdv;
    @(posedge clk);
    acc = 1'b0;
    rdv = '0;
    if (rst) begin
      busy_left = SETS;
      mv1 = 1'b0; mv2 = 1'b0;
      md1 = '0;   md2 = '0;
      last1 = '0; last2 = '0;
    end else begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) mem_m[w][s] = '0;
        end
      end else begin
        for (int w = 0; w < WAYS; w++)
          for (int b = 0; b < LB; b++)
            if (wen[w] && wstrb[b]) mem_m[w][windex][b*8 +: 8] = wdata[b*8 +: 8];
        if (ren) begin
          acc = 1'b1;
          rdv = {mem_m[1][rindex], mem_m[0][rindex]};
        end
      end
      mv2 = mv1; md2 = md1;
      mv1 = acc; md1 = rdv;
      if (mv1) last1 = md1;
      if (mv2) last2 = md2;
    end
    #1;
    chk("model_busy_l1",   512'(busy1), 512'(busy_left > 0));
    chk("model_busy_l2",   512'(busy2), 512'(busy_left > 0));
    chk("model_rvalid_l1", 512'(rv1), 512'(mv1));
    chk("model_rvalid_l2", 512'(rv2), 512'(mv2));
    chk("model_rdata_l1",  rd1, last1);
    chk("model_rdata_l2",  rd2, last2);
  endtask

  typedef struct {
    logic          rst;
    logic          ren;
    logic [IW-1:0] rindex;
    logic [1:0]    wen;
    logic [LB-1:0] wstrb;
    logic [IW-1:0] windex;
    logic [7:0]    wbyte;
    logic          e_busy;
    logic          e_rv1;
    logic          e_rv2;
    logic [7:0]    e_w0lo;
    logic [7:0]    e_w0hi;
    logic [7:0]    e_w1;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p1, p2, n;
    rst = 1'b1; ren = 1'b0; rindex = '0; wen = '0; wstrb = '0; windex = '0; wdata = '0;
    busy_left = SETS;
    mv1 = 1'b0; mv2 = 1'b0; md1 = '0; md2 = '0; last1 = '0; last2 = '0;
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) mem_m[w][s] = '0;

    //          rst  ren  ri    wen    wstrb         wi    wb      busy rv1  rv2  w0lo   w0hi   w1
    vt[0]  = '{1'b1,1'b0,3'd0,2'b00,32'h0,        3'd0,8'h00, 1'b1,1'b0,1'b0,8'h00,8'h00,8'h00};
    vt[1]  = '{1'b1,1'b0,3'd0,2'b00,32'h0,        3'd0,8'h00, 1'b1,1'b0,1'b0,8'h00,8'h00,8'h00};
    vt[2]  = '{1'b0,1'b1,3'd3,2'b00,32'h0,        3'd0,8'h00, 1'b1,1'b0,1'b0,8'h00,8'h00,8'h00};
    vt[3]  = '{1'b0,1'b1,3'd3,2'b00,32'h0,        3'd0,8'h00, 1'b1,1'b0,1'b0,8'h00,8'h00,8'h00};
    vt[4]  = '{1'b0,1'b1,3'd3,2'b00,32'h0,        3'd0,8'h00, 1'b1,1'b0,1'b0,8'h00,8'h00,8'h00};
    vt[5]  = '{1'b0,1'b1,3'd3,2'b11,32'hFFFFFFFF, 3'd3,8'hEE, 1'b1,1'b0,1'b0,8'h00,8'h00,8'h00};
    vt[6]  = '{1'b0,1'b1,3'd3,2'b00,32'h0,        3'd0,8'h00, 1'b1,1'b0,1'b0,8'h00,8'h00,8'h00};
    vt[7]  = '{1'b0,1'b1,3'd3,2'b00,32'h0,        3'd0,8'h00, 1'b1,1'b0,1'b0,8'h00,8'h00,8'h00};
    vt[8]  = '{1'b0,1'b1,3'd3,2'b00,32'h0,        3'd0,8'h00, 1'b1,1'b0,1'b0,8'h00,8'h00,8'h00};
    vt[9]  = '{1'b0,1'b1,3'd3,2'b00,32'h0,        3'd0,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00,8'h00};
    vt[10] = '{1'b0,1'b1,3'd3,2'b00,32'h0,        3'd0,8'h00, 1'b0,1'b1,1'b0,8'h00,8'h00,8'h00};
    vt[11] = '{1'b0,1'b0,3'd0,2'b10,32'hFFFFFFFF, 3'd5,8'hA5, 1'b0,1'b0,1'b1,8'h00,8'h00,8'h00};
    vt[12] = '{1'b0,1'b1,3'd5,2'b00,32'h0,        3'd0,8'h00, 1'b0,1'b1,1'b0,8'h00,8'h00,8'hA5};
    vt[13] = '{1'b0,1'b0,3'd0,2'b01,32'hFFFFFFFF, 3'd5,8'h11, 1'b0,1'b0,1'b1,8'h00,8'h00,8'h00};
    vt[14] = '{1'b0,1'b1,3'd5,2'b01,32'h0000000F, 3'd5,8'hFF, 1'b0,1'b1,1'b0,8'hFF,8'h11,8'hA5};
    vt[15] = '{1'b0,1'b0,3'd0,2'b11,32'h0,        3'd5,8'h33, 1'b0,1'b0,1'b1,8'h00,8'h00,8'h00};
    vt[16] = '{1'b0,1'b1,3'd2,2'b00,32'h0,        3'd0,8'h00, 1'b0,1'b1,1'b0,8'h00,8'h00,8'h00};
    vt[17] = '{1'b0,1'b0,3'd0,2'b11,32'hFFFFFFFF, 3'd2,8'h77, 1'b0,1'b0,1'b1,8'h00,8'h00,8'h00};
    vt[18] = '{1'b0,1'b1,3'd2,2'b00,32'h0,        3'd0,8'h00, 1'b0,1'b1,1'b0,8'h77,8'h77,8'h77};
    vt[19] = '{1'b0,1'b0,3'd0,2'b00,32'h0,        3'd0,8'h00, 1'b0,1'b0,1'b1,8'h00,8'h00,8'h00};
    vt[20] = '{1'b0,1'b1,3'd5,2'b00,32'h0,        3'd0,8'h00, 1'b0,1'b1,1'b0,8'hFF,8'h11,8'hA5};
    vt[21] = '{1'b0,1'b0,3'd0,2'b00,32'h0,        3'd0,8'h00, 1'b0,1'b0,1'b1,8'h00,8'h00,8'h00};

    // Directed vectors: reset, sweep, write/read, collision, latency ordering.
    for (int i = 0; i < NV; i++) begin
      rst = vt[i].rst; ren = vt[i].ren; rindex = vt[i].rindex;
      wen = vt[i].wen; wstrb = vt[i].wstrb; windex = vt[i].windex;
      wdata = {LB{vt[i].wbyte}};
      tick();
      chk($sformatf("vec%0d_busy", i), 512'(busy1), 512'(vt[i].e_busy));
      chk($sformatf("vec%0d_rv1", i),  512'(rv1),   512'(vt[i].e_rv1));
      chk($sformatf("vec%0d_rv2", i),  512'(rv2),   512'(vt[i].e_rv2));
      if (vt[i].e_rv1) begin
        chk($sformatf("vec%0d_w0lo", i), 512'(rd1[7:0]),     512'(vt[i].e_w0lo));
        chk($sformatf("vec%0d_w0hi", i), 512'(rd1[255:248]), 512'(vt[i].e_w0hi));
        chk($sformatf("vec%0d_w1", i),   512'(rd1[263:256]), 512'(vt[i].e_w1));
      end
      if (i == 17) chk("lat2_old_data", 512'(rd2[7:0]), 512'(8'h00));
      if (i == 19) chk("lat2_new_data", 512'(rd2[7:0]), 512'(8'h77));
    end

    // Tag each set in way1 with a distinct byte so read order is observable.
    for (int k = 0; k < SETS; k++) begin
      ren = 1'b0; wen = 2'b10; wstrb = '1; windex = IW'(k);
      wdata = {LB{8'(8'h40 + k)}};
      tick();
    end

    // Back-to-back reads of every set with a colliding write to set 4.
    p1 = 0; p2 = 0;
    for (int k = 0; k < SETS; k++) begin
      ren = 1'b1; rindex = IW'(k);
      if (k == 4) begin
        wen = 2'b01; wstrb = '1; windex = 3'd4; wdata = {LB{8'hC4}};
      end else begin
        wen = 2'b00; wstrb = '0;
      end
      tick();
      if (rv1) p1++;
      if (rv2) p2++;
      chk($sformatf("b2b_way1_idx%0d", k), 512'(rd1[263:256]), 512'(8'(8'h40 + k)));
      if (k == 4) chk("b2b_fwd_idx4", 512'(rd1[7:0]), 512'(8'hC4));
    end
    ren = 1'b0; wen = '0; wstrb = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (rv1) p1++;
      if (rv2) p2++;
    end
    chk("b2b_pulses_l1", 512'(p1), 512'(SETS));
    chk("b2b_pulses_l2", 512'(p2), 512'(SETS));

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      rst    = ($urandom_range(0, 149) == 0);
      ren    = $urandom_range(0, 1) == 1;
      rindex = IW'($urandom_range(0, SETS - 1));
      wen    = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       wstrb = '0;
        1:       wstrb = '1;
        default: wstrb = $urandom;
      endcase
      windex = ($urandom_range(0, 1) == 1) ? rindex : IW'($urandom_range(0, SETS - 1));
      for (int j = 0; j < LW / 32; j++) wdata[j*32 +: 32] = $urandom;
      tick();
    end

    // Let any sweep finish, then reset in the shadow of a latency-2 read.
    rst = 1'b0; ren = 1'b0; wen = '0; wstrb = '0;
    n = 0;
    while (busy1 && n < 20) begin
      tick();
      n++;
    end
    chk("pre_rst_idle", 512'(busy1), 512'(1'b0));
    ren = 1'b1; rindex = 3'd1;
    tick();
    rst = 1'b1; ren = 1'b0;
    tick();
    chk("rst_drop_rv2",  512'(rv2),   512'(1'b0));
    chk("rst_busy2",     512'(busy2), 512'(1'b1));
    chk("rst_rdata2",    rd2, 512'(0));
    rst = 1'b0; ren = 1'b1; rindex = 3'd1;
    n = 0;
    while (busy2 && n < 20) begin
      tick();
      n++;
    end
    chk("rst_sweep_len", 512'(n), 512'(SETS));
    tick();
    chk("post_sweep_rv1",  512'(rv1), 512'(1'b1));
    chk("post_sweep_zero", rd1, 512'(0));
    ren = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_data_bank.md
Name: dcache_data_bank

Overview:
- Multi-way data array for the L1 data cache: one line per way per set, byte-strobed writes, one read port returning all ways of a set.
- Same-cycle write-to-read collisions are forwarded byte-by-byte, so a read always sees a write issued in the same cycle.
- Adds configurable read latency (1 or 2) and a post-reset zero-fill sweep, so tags/data never expose X after reset.
- Sits between the dcache control FSM (tag compare / refill / store) and the way-select mux.

Parameters:
- WAYS, 2, number of ways; each way is a separate RAM.
- SETS, 128, sets per way (power of two); IDX_W = clog2(SETS).
- LINE_BYTES, 32, bytes per line; LINE_W = 8*LINE_BYTES.
- READ_LATENCY, 1, cycles from ren to rvalid; legal values are 1 and 2, anything else is an elaboration error.
- INIT_ON_RESET, 1, 1 = zero-fill all sets after reset; 0 = no sweep.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- init_busy  out  1  zero-fill sweep in progress; ren and wen are ignored while high
- ren  in  1  read request
- rindex  in  IDX_W  read set index
- wen  in  WAYS  per-way write enable
- wstrb  in  LINE_BYTES  byte write strobes, shared by all enabled ways
- windex  in  IDX_W  write set index
- wdata  in  LINE_W  write line data
- rvalid  out  1  read data valid (one-cycle pulse per read)
- rdata  out  WAYS*LINE_W  way w occupies bits [w*LINE_W +: LINE_W]

Behaviour:
- Reset values: rvalid=0, rdata=0, init_busy=INIT_ON_RESET. RAM contents are not cleared by rst itself.
- FSM states:
  - INIT: counter cnt starts at 0. Each cycle, write zeros to set cnt in all ways with all strobes set. After cnt==SETS-1 is written, go to RUN; init_busy=0 from the next cycle. Sweep length is exactly SETS cycles.
  - RUN: normal operation. With INIT_ON_RESET=0, reset goes straight to RUN.
- During INIT: external wen and ren are ignored, no rvalid is produced, and rdata holds 0.
- Write (RUN): at the clock edge, byte b of way w at windex is updated iff wen[w] & wstrb[b]. wen with wstrb==0 is a no-op.
- Read (RUN): ren at cycle T gives rvalid=1 at T+READ_LATENCY.
  - rdata = contents of rindex after applying every write issued at cycles <= T, including the write in cycle T.
  - Writes at cycles > T are never visible to that read, including at T+1 when READ_LATENCY=2.
- Collision forwarding: the RAM is read-first. At T, register coll[w] = wen[w] & (windex==rindex) & ren, together with wstrb and wdata. At T+1, for each way and byte: coll[w] & wstrb_q[b] ? wdata_q : ram_out. For READ_LATENCY=2 the merged result is registered once more.
- Throughput: one read per cycle, fully pipelined. Simultaneous read and write to different indexes are independent.
- rdata holds its last value when no read completes; only rvalid pulses.
- rst mid-operation: in-flight reads are dropped (rvalid=0 the cycle after rst), forwarding registers are cleared, and the sweep restarts at cnt=0. rst mid-INIT also restarts the sweep.
- Timing: RAM read-first, latency 1, no output register inside the RAM primitive; byte-write width 8.

Decomposition:
- Shared package dcache_pkg: LINE_BYTES/LINE_W defaults, clog2 helper, FSM state encoding (INIT, RUN).
- Sub-module dcache_way_ram: one way; simple dual-port byte-write RAM, read-first, latency 1; parameters SETS and LINE_BYTES. Instantiated WAYS times through generate.
- Top level holds the FSM, init counter, the write-mux between sweep and external ports, forwarding registers, and the optional output stage.

Test Plan:
- INIT sweep (SETS=8): release rst, hold ren=1 rindex=3 → init_busy high exactly 8 cycles, no rvalid during sweep; first read after sweep returns all-zero for both ways.
- Basic write/read, READ_LATENCY=1: write way1 idx5 wstrb=all-ones wdata=0xA5..A5; ren idx5 the next cycle → rvalid next cycle, way1=0xA5..A5, way0=0.
- Same-cycle collision: idx5 way0 holds 0x11..11; in one cycle issue ren idx5 and wen=01, wstrb=0x0000000F, wdata=0xFF..FF → way0 bytes 0-3 = 0xFF, bytes 4-31 = 0x11.
- READ_LATENCY=2 ordering: ren idx2 at T, write idx2 all bytes 0x77.. at T+1 → rvalid at T+2 with old data; a second ren at T+2 returns 0x77..
- Back-to-back reads to idx0..7 every cycle, with a concurrent write to idx4 in the same cycle as its read → 8 consecutive rvalid pulses, in order; idx4 shows the forwarded data.
- Reset mid-read: ren at T, rst at T+1 (READ_LATENCY=2) → no rvalid at T+2; init_busy=1 and the sweep restarts from 0.
